divider16by8: RTL

Sequential 16-bit by 8-bit unsigned restoring divider. It is the inverse companion of the 8-bit multiplier datapath. It takes a 16-bit product-width dividend and an 8-bit divisor, and produces a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic unit. It is also used in-system to check multiplier results: dividing `result` by `y` must return `x` with remainder 0.

---
 rtl/arith_pkg.sv | 16 +
 rtl/divider_step.sv | 25 ++
 rtl/divider16by8.sv | 108 ++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit: divider FSM states and fixed constants.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS  = 16;
    localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

    // Count value on which the last restoring step is performed.
    localparam logic [4:0]  DIV_LAST_COUNT = 5'(DIV_ITERS - 1);

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, compare with the divisor, subtract if it fits.
module divider_step (
    input  logic [8:0] rem_in,
    input  logic       q_msb,
    input  logic [7:0] div,
    output logic [8:0] rem_out,
    output logic       q_bit
);

    logic [8:0] trial;
    logic [8:0] wide_div;

    // rem_in is always below div, so trial - div fits in 9 bits without wrapping.
    always_comb begin
        trial    = {rem_in[7:0], q_msb};
        wide_div = {1'b0, div};
        rem_out  = trial;
        q_bit    = 1'b0;
        if (trial >= wide_div) begin
            rem_out = trial - wide_div;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/divider16by8.sv
// Sequential 16/8 unsigned restoring divider producing one quotient bit per clock.
module divider16by8
    import arith_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        PRONTO,
    output logic        BUSY,
    output logic        DIV_ZERO
);

    div_state_t  state, next_state;
    logic [15:0] q_reg;
    logic [8:0]  r_reg;
    logic [7:0]  d_reg;
    logic [4:0]  count;
    logic        accept, load_zero, finish;
    logic [8:0]  step_rem;
    logic        step_bit;

    divider_step u_step (
        .rem_in  (r_reg),
        .q_msb   (q_reg[15]),
        .div     (d_reg),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_zero  = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    if (divisor != 8'd0) begin
                        next_state = ST_ITER;
                        accept     = 1'b1;
                    end else begin
                        next_state = ST_DONE;
                        load_zero  = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (count == DIV_LAST_COUNT) begin
                    next_state = ST_DONE;
                    finish     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Results are published only on completion, so quotient/remainder keep the last result while iterating.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            PRONTO    <= 1'b0;
            BUSY      <= 1'b0;
            DIV_ZERO  <= 1'b0;
        end else begin
            BUSY <= (next_state == ST_ITER);
            if (accept) begin
                q_reg    <= dividend;
                r_reg    <= '0;
                d_reg    <= divisor;
                count    <= '0;
                PRONTO   <= 1'b0;
                DIV_ZERO <= 1'b0;
            end else if (load_zero) begin
                quotient  <= DIV_ZERO_Q;
                remainder <= dividend[7:0];
                DIV_ZERO  <= 1'b1;
                PRONTO    <= 1'b1;
            end else if (state == ST_ITER) begin
                q_reg <= {q_reg[14:0], step_bit};
                r_reg <= step_rem;
                count <= count + 5'd1;
                if (finish) begin
                    quotient  <= {q_reg[14:0], step_bit};
                    remainder <= step_rem[7:0];
                    PRONTO    <= 1'b1;
                end
            end
        end
    end

endmodule
